// File: rtl/chess_pkg.sv
// Shared types and board geometry for the chess move-selection logic.
package chess_pkg;

    typedef logic [2:0] tile_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECTED = 2'd1,
        ST_ISSUE    = 2'd2
    } sel_state_e;

    localparam int TILE        = 45;
    localparam int X0          = 140;
    localparam int Y0          = 60;
    localparam int BOARD_TILES = 8;

    // A square belongs to the side to move when it holds a piece of that colour.
    function automatic logic is_own(input logic occupied, input logic white,
                                    input logic white_turn);
        return occupied && (white == white_turn);
    endfunction

endpackage

// File: rtl/chess_click_edge.sv
// Rising-edge detector on the (already synchronous) mouse button level.
module chess_click_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_i,
    output logic click_o
);

    logic btn_q;

    // Held high in reset so a button still down at release is not a new click.
    always_ff @(posedge Clk) begin
        if (Reset) btn_q <= 1'b1;
        else       btn_q <= btn_i;
    end

    assign click_o = btn_i & ~btn_q;

endmodule

// File: rtl/chess_move_select.sv
// Two-click move entry: pick an own piece, then a target square; the move is
// offered to the consumer with a valid/ready handshake.
module chess_move_select
    import chess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 67108864
) (
    input  logic      Clk,
    input  logic      Reset,
    input  logic      mouse_btn,
    input  logic      on_board,
    input  tile_idx_t tile_row,
    input  tile_idx_t tile_col,
    input  logic      sq_occupied,
    input  logic      sq_white,
    input  logic      white_turn,
    input  logic      move_ready,
    output logic      move_valid,
    output tile_idx_t src_row,
    output tile_idx_t src_col,
    output tile_idx_t dst_row,
    output tile_idx_t dst_col,
    output logic      capture,
    output logic      sel_active,
    output tile_idx_t sel_row,
    output tile_idx_t sel_col
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sel_state_e       state_q, state_d;
    tile_idx_t        src_row_q, src_row_d, src_col_q, src_col_d;
    tile_idx_t        dst_row_q, dst_row_d, dst_col_q, dst_col_d;
    logic             capture_q, capture_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             click;
    logic             own;
    logic             same_sq;

    chess_click_edge u_click_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .btn_i   (mouse_btn),
        .click_o (click)
    );

    assign own     = is_own(sq_occupied, sq_white, white_turn);
    assign same_sq = (tile_row == src_row_q) && (tile_col == src_col_q);

    always_comb begin
        state_d   = state_q;
        src_row_d = src_row_q;
        src_col_d = src_col_q;
        dst_row_d = dst_row_q;
        dst_col_d = dst_col_q;
        capture_d = capture_q;
        cnt_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (click && on_board && own) begin
                    src_row_d = tile_row;
                    src_col_d = tile_col;
                    state_d   = ST_SELECTED;
                end
            end
            ST_SELECTED: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A click in the timeout cycle wins over the timeout.
                if (click) begin
                    if (!on_board || same_sq) begin
                        state_d = ST_IDLE;
                    end else if (own) begin
                        src_row_d = tile_row;
                        src_col_d = tile_col;
                        cnt_d     = '0;
                    end else begin
                        dst_row_d = tile_row;
                        dst_col_d = tile_col;
                        capture_d = sq_occupied;
                        state_d   = ST_ISSUE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (move_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != ST_SELECTED) cnt_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            src_row_q <= '0;
            src_col_q <= '0;
            dst_row_q <= '0;
            dst_col_q <= '0;
            capture_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_row_q <= src_row_d;
            src_col_q <= src_col_d;
            dst_row_q <= dst_row_d;
            dst_col_q <= dst_col_d;
            capture_q <= capture_d;
            cnt_q     <= cnt_d;
        end
    end

    assign move_valid = (state_q == ST_ISSUE);
    assign sel_active = (state_q != ST_IDLE);
    assign src_row    = src_row_q;
    assign src_col    = src_col_q;
    assign sel_row    = src_row_q;
    assign sel_col    = src_col_q;
    assign dst_row    = dst_row_q;
    assign dst_col    = dst_col_q;
    assign capture    = capture_q;

endmodule

// File: tb/tb_chess_move_select.sv
// Directed bench with a cycle-level reference model of the move selector.
module tb_chess_move_select;

    localparam int TO = 16;

    logic       Clk = 1'b0;
    logic       Reset, mouse_btn, on_board, sq_occupied, sq_white, white_turn, move_ready;
    logic [2:0] tile_row, tile_col;
    logic       move_valid, capture, sel_active;
    logic [2:0] src_row, src_col, dst_row, dst_col, sel_row, sel_col;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    chess_move_select #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset(Reset), .mouse_btn(mouse_btn), .on_board(on_board),
        .tile_row(tile_row), .tile_col(tile_col), .sq_occupied(sq_occupied),
        .sq_white(sq_white), .white_turn(white_turn), .move_ready(move_ready),
        .move_valid(move_valid), .src_row(src_row), .src_col(src_col),
        .dst_row(dst_row), .dst_col(dst_col), .capture(capture),
        .sel_active(sel_active), .sel_row(sel_row), .sel_col(sel_col)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: mode 0=nothing chosen, 1=piece chosen, 2=move offered.
    int         m_mode = 0;
    int         m_age  = 0;
    logic [2:0] m_sr = 0, m_sc = 0, m_dr = 0, m_dc = 0;
    logic       m_cap  = 0;
    logic       m_prev = 1;
    bit         started = 0;

    always @(posedge Clk) begin : model
        logic ev, mine;
        if (Reset) begin
            m_mode = 0; m_age = 0; m_sr = 0; m_sc = 0; m_dr = 0; m_dc = 0;
            m_cap = 0; m_prev = 1; started = 1;
        end else begin
            ev     = mouse_btn && !m_prev;
            m_prev = mouse_btn;
            mine   = sq_occupied && (sq_white == white_turn);
            if (m_mode == 0) begin
                if (ev && on_board && mine) begin
                    m_mode = 1; m_sr = tile_row; m_sc = tile_col; m_age = 0;
                end
            end else if (m_mode == 1) begin
                if (ev) begin
                    if (!on_board || (tile_row == m_sr && tile_col == m_sc)) m_mode = 0;
                    else if (mine) begin m_sr = tile_row; m_sc = tile_col; m_age = 0; end
                    else begin m_dr = tile_row; m_dc = tile_col; m_cap = sq_occupied; m_mode = 2; end
                end else if (m_age == TO - 1) m_mode = 0;
                else m_age++;
            end else if (move_ready) m_mode = 0;
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            chk("m_valid", move_valid, (m_mode == 2));
            chk("m_sel_active", sel_active, (m_mode != 0));
            chk("m_src_row", src_row, m_sr);
            chk("m_src_col", src_col, m_sc);
            chk("m_sel_row", sel_row, m_sr);
            chk("m_sel_col", sel_col, m_sc);
            if (m_mode == 2) begin
                chk("m_dst_row", dst_row, m_dr);
                chk("m_dst_col", dst_col, m_dc);
                chk("m_capture", capture, m_cap);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_sq(input int r, input int c, input bit occ, input bit wht, input bit onb);
        tile_row = 3'(r); tile_col = 3'(c);
        sq_occupied = occ; sq_white = wht; on_board = onb;
    endtask

    task automatic do_click(input int r, input int c, input bit occ, input bit wht, input bit onb);
        set_sq(r, c, occ, wht, onb);
        mouse_btn = 1'b1;
        tick();
        mouse_btn = 1'b0;
        tick();
    endtask

    task automatic handshake();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
    endtask

    initial begin
        int n;
        Reset = 1'b1; mouse_btn = 1'b0; move_ready = 1'b0; white_turn = 1'b0;
        set_sq(0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_valid", move_valid, 0);
        chk("rst_sel_active", sel_active, 0);
        chk("rst_src_row", src_row, 0);
        chk("rst_capture", capture, 0);
        Reset = 1'b0;
        white_turn = 1'b1;
        tick();

        // Pawn push with a stalled consumer
        do_click(6, 4, 1, 1, 1);
        chk("sel_64_active", sel_active, 1);
        chk("sel_64_row", sel_row, 6);
        chk("sel_64_col", sel_col, 4);
        do_click(4, 4, 0, 0, 1);
        chk("push_valid", move_valid, 1);
        chk("push_src", {src_row, src_col}, {3'd6, 3'd4});
        chk("push_dst", {dst_row, dst_col}, {3'd4, 3'd4});
        chk("push_capture", capture, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("push_hold_valid", move_valid, 1);
            chk("push_hold_dst_row", dst_row, 4);
        end
        handshake();
        chk("push_clear_valid", move_valid, 0);
        chk("push_clear_sel", sel_active, 0);

        // Reclick on the source deselects
        do_click(7, 1, 1, 1, 1);
        do_click(7, 1, 1, 1, 1);
        chk("desel_active", sel_active, 0);
        chk("desel_valid", move_valid, 0);

        // Reselect then capture
        do_click(6, 0, 1, 1, 1);
        do_click(6, 1, 1, 1, 1);
        chk("resel_src_col", src_col, 1);
        chk("resel_active", sel_active, 1);
        do_click(5, 1, 1, 0, 1);
        chk("cap_valid", move_valid, 1);
        chk("cap_src", {src_row, src_col}, {3'd6, 3'd1});
        chk("cap_dst", {dst_row, dst_col}, {3'd5, 3'd1});
        chk("cap_capture", capture, 1);
        handshake();

        // Timeout with no click
        do_click(6, 2, 1, 1, 1);
        repeat (14) tick();
        chk("to_before", sel_active, 1);
        tick();
        chk("to_after", sel_active, 0);

        // Click landing on the timeout cycle
        do_click(6, 2, 1, 1, 1);
        repeat (14) tick();
        do_click(4, 2, 0, 0, 1);
        chk("to_click_valid", move_valid, 1);
        chk("to_click_dst_row", dst_row, 4);
        handshake();

        // Held button: single click, so selection lasts until timeout
        set_sq(6, 3, 1, 1, 1);
        mouse_btn = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sel_active) n++;
        end
        chk("held_sel_cycles", n, TO);
        mouse_btn = 1'b0;
        tick();

        // Off-board click cancels; opponent piece in idle is ignored
        do_click(6, 3, 1, 1, 1);
        chk("cancel_pre", sel_active, 1);
        do_click(0, 0, 0, 0, 0);
        chk("cancel_post", sel_active, 0);
        do_click(1, 1, 1, 0, 1);
        chk("black_ignored", sel_active, 0);

        // Turn flip and stray ready while selected
        do_click(6, 5, 1, 1, 1);
        white_turn = 1'b0;
        repeat (3) tick();
        chk("turn_flip_sel", sel_active, 1);
        white_turn = 1'b1;
        handshake();
        chk("ready_in_sel_active", sel_active, 1);
        chk("ready_in_sel_valid", move_valid, 0);
        do_click(6, 5, 1, 1, 1);
        chk("turn_desel", sel_active, 0);

        // Reset during a pending move, button held across release
        do_click(6, 6, 1, 1, 1);
        do_click(5, 6, 0, 0, 1);
        chk("rst_issue_pre", move_valid, 1);
        set_sq(6, 6, 1, 1, 1);
        mouse_btn = 1'b1;
        Reset = 1'b1;
        tick();
        chk("rst_issue_valid", move_valid, 0);
        chk("rst_issue_sel", sel_active, 0);
        chk("rst_issue_dst_row", dst_row, 0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_held_noclick", sel_active, 0);
        end
        mouse_btn = 1'b0;
        tick();
        chk("rst_release_idle", sel_active, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
